// File: rtl/ultra_wide_differencer.sv
// 128-bit first-difference pipeline: y = x - prev, as four 32-bit borrow-ripple slices.
// Optional borrow flag output enabled by defining ULTRA_WIDE_DIFFERENCER_BORROW_EN.
module ultra_wide_differencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         pass,
  input  logic         clear,
  input  logic [127:0] x,
  output logic [127:0] y_r,
  output logic         y_vld_r
`ifdef ULTRA_WIDE_DIFFERENCER_BORROW_EN
  ,
  output logic         borrow_r
`endif
);

  logic [127:0] r_prev;
  logic [3:0]   r_valid;

  logic [31:0]  r_s0_d;
  logic         r_s0_c;
  logic [95:0]  r_s0_a;
  logic [95:0]  r_s0_b;

  logic [63:0]  r_s1_d;
  logic         r_s1_c;
  logic [63:0]  r_s1_a;
  logic [63:0]  r_s1_b;

  logic [95:0]  r_s2_d;
  logic         r_s2_c;
  logic [31:0]  r_s2_a;
  logic [31:0]  r_s2_b;

  logic [127:0] r_s3_d;

  // Subtraction is x + ~eff_prev + 1; clear forces eff_prev to zero.
  logic [127:0] w_nprev;
  logic [32:0]  w_s0;
  logic [32:0]  w_s1;
  logic [32:0]  w_s2;

  assign w_nprev = clear ? {128{1'b1}} : ~r_prev;
  assign w_s0    = {1'b0, x[31:0]} + {1'b0, w_nprev[31:0]} + 33'd1;
  assign w_s1    = {1'b0, r_s0_a[31:0]} + {1'b0, r_s0_b[31:0]} + {32'd0, r_s0_c};
  assign w_s2    = {1'b0, r_s1_a[31:0]} + {1'b0, r_s1_b[31:0]} + {32'd0, r_s1_c};

`ifdef ULTRA_WIDE_DIFFERENCER_BORROW_EN
  logic [32:0]  w_s3;
  logic         r_s3_bor;
  assign w_s3 = {1'b0, r_s2_a} + {1'b0, r_s2_b} + {32'd0, r_s2_c};
`else
  logic [31:0]  w_s3;
  assign w_s3 = r_s2_a + r_s2_b + {31'd0, r_s2_c};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 128'd0;
      r_valid <= 4'd0;
    end else begin
      r_valid <= {r_valid[2:0], pass};
      if (pass) begin
        r_prev <= x;
      end else if (clear) begin
        r_prev <= 128'd0;
      end else begin
        r_prev <= r_prev;
      end
    end
  end

  // Each slice stage loads only when its incoming valid bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_d <= 32'd0;
      r_s0_c <= 1'b0;
      r_s0_a <= 96'd0;
      r_s0_b <= 96'd0;
      r_s1_d <= 64'd0;
      r_s1_c <= 1'b0;
      r_s1_a <= 64'd0;
      r_s1_b <= 64'd0;
      r_s2_d <= 96'd0;
      r_s2_c <= 1'b0;
      r_s2_a <= 32'd0;
      r_s2_b <= 32'd0;
    end else begin
      if (pass) begin
        r_s0_d <= w_s0[31:0];
        r_s0_c <= w_s0[32];
        r_s0_a <= x[127:32];
        r_s0_b <= w_nprev[127:32];
      end
      if (r_valid[0]) begin
        r_s1_d <= {w_s1[31:0], r_s0_d};
        r_s1_c <= w_s1[32];
        r_s1_a <= r_s0_a[95:32];
        r_s1_b <= r_s0_b[95:32];
      end
      if (r_valid[1]) begin
        r_s2_d <= {w_s2[31:0], r_s1_d};
        r_s2_c <= w_s2[32];
        r_s2_a <= r_s1_a[63:32];
        r_s2_b <= r_s1_b[63:32];
      end
    end
  end

  // Final slice, then a registered output stage that holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_d  <= 128'd0;
      y_r     <= 128'd0;
      y_vld_r <= 1'b0;
`ifdef ULTRA_WIDE_DIFFERENCER_BORROW_EN
      r_s3_bor <= 1'b0;
      borrow_r <= 1'b0;
`endif
    end else begin
      y_vld_r <= r_valid[3];
      if (r_valid[2]) begin
        r_s3_d <= {w_s3[31:0], r_s2_d};
`ifdef ULTRA_WIDE_DIFFERENCER_BORROW_EN
        r_s3_bor <= ~w_s3[32];
`endif
      end
      if (r_valid[3]) begin
        y_r <= r_s3_d;
`ifdef ULTRA_WIDE_DIFFERENCER_BORROW_EN
        borrow_r <= r_s3_bor;
`endif
      end
    end
  end

endmodule
